// File: rtl/exu_muldiv.sv
// Purpose : RV32M multiply/divide unit beside the EX-stage ALU; stalls EX while an op is in flight.
// Latency : MUL* MUL_LAT+1 cycles, DIV*/REM* XLEN+1 cycles, divide-by-zero/overflow 1 cycle.
// Backpr. : no result backpressure; o_ex_stall holds the pipeline until the single-cycle o_valid pulse.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_valid           M-extension op present in EX (held while o_ex_stall)
//   i_funct3          0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   i_src1, i_src2    forwarded operands
//   i_rd_addr         destination register
//   i_flush           kill any in-flight op
//   o_ex_stall        combinational stall to IF/ID/EX
//   o_valid           single-cycle result pulse
//   o_result          result, held outside the valid cycle
//   o_rd_addr         rd of the completing op, held outside the valid cycle
//   o_busy            registered, unit not idle
module exu_muldiv #(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_valid,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_src1,
    input  logic [XLEN-1:0] i_src2,
    input  logic [4:0]      i_rd_addr,
    input  logic            i_flush,
    output logic            o_ex_stall,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result,
    output logic [4:0]      o_rd_addr,
    output logic            o_busy
);

    localparam int CMAX = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]   cnt;
    logic [1:0]      op_q;      // funct3[1:0]; funct3[2] is captured by the state itself
    logic [4:0]      rd_q;
    logic [XLEN-1:0] src1_q;
    logic [XLEN-1:0] src2_q;
    logic [XLEN-1:0] quo_q;     // dividend magnitude shifting out, quotient bits shifting in
    logic [XLEN-1:0] rem_q;     // partial remainder
    logic [XLEN-1:0] dvs_q;     // divisor magnitude
    logic            busy_q;

    // ---------------- accept-side decode ----------------
    logic            accept;
    logic            is_div_in;
    logic            sgn_in;
    logic            div_zero_in;
    logic            div_ovf_in;
    logic            special_in;
    logic [XLEN-1:0] special_res;
    logic [XLEN-1:0] dvd_mag_in;
    logic [XLEN-1:0] dvs_mag_in;

    always_comb begin
        accept      = i_valid && (state == S_IDLE) && !i_flush;
        is_div_in   = i_funct3[2];
        sgn_in      = !i_funct3[0];
        div_zero_in = (i_src2 == '0);
        div_ovf_in  = sgn_in && (i_src1 == MIN_NEG) && (i_src2 == '1);
        special_in  = is_div_in && (div_zero_in || div_ovf_in);
        // funct3[1] selects remainder for the divide group
        if (i_funct3[1])
            special_res = div_zero_in ? i_src1 : '0;
        else
            special_res = div_zero_in ? '1 : i_src1;
        dvd_mag_in = (sgn_in && i_src1[XLEN-1]) ? (-i_src1) : i_src1;
        dvs_mag_in = (sgn_in && i_src2[XLEN-1]) ? (-i_src2) : i_src2;
    end

    // ---------------- multiply ----------------
    logic            mul_a_sgn;
    logic            mul_b_sgn;
    logic [2*XLEN-1:0] mul_a;
    logic [2*XLEN-1:0] mul_b;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0] mul_res;

    always_comb begin
        mul_a_sgn = (op_q == 2'd1) || (op_q == 2'd2);   // MULH, MULHSU
        mul_b_sgn = (op_q == 2'd1);                     // MULH only
        mul_a     = {{XLEN{mul_a_sgn & src1_q[XLEN-1]}}, src1_q};
        mul_b     = {{XLEN{mul_b_sgn & src2_q[XLEN-1]}}, src2_q};
        // Truncated 2*XLEN product of sign-extended operands is exact for all four ops
        prod      = mul_a * mul_b;
        mul_res   = (op_q == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    // ---------------- restoring divide step ----------------
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   rem_diff;
    logic [XLEN-1:0] rem_nxt;
    logic [XLEN-1:0] quo_nxt;
    logic            div_sgn;
    logic            neg_q;
    logic            neg_r;
    logic [XLEN-1:0] div_res;

    always_comb begin
        rem_sh   = {rem_q, quo_q[XLEN-1]};
        rem_diff = rem_sh - {1'b0, dvs_q};
        // Borrow out of the extra top bit means the trial subtract went negative: restore
        if (!rem_diff[XLEN]) begin
            rem_nxt = rem_diff[XLEN-1:0];
            quo_nxt = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            rem_nxt = rem_sh[XLEN-1:0];
            quo_nxt = {quo_q[XLEN-2:0], 1'b0};
        end
        div_sgn = !op_q[0];
        neg_q   = div_sgn && (src1_q[XLEN-1] ^ src2_q[XLEN-1]);
        neg_r   = div_sgn && src1_q[XLEN-1];
        if (op_q[1])
            div_res = neg_r ? (-rem_nxt) : rem_nxt;
        else
            div_res = neg_q ? (-quo_nxt) : quo_nxt;
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (!is_div_in)     state_nxt = S_MUL;
                    else if (special_in) state_nxt = S_DONE;
                    else                 state_nxt = S_DIV;
                end
            end
            S_MUL:   if (cnt == '0) state_nxt = S_DONE;
            S_DIV:   if (cnt == '0) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (i_flush) state_nxt = S_IDLE;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            op_q      <= '0;
            rd_q      <= '0;
            src1_q    <= '0;
            src2_q    <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            busy_q    <= 1'b0;
            o_result  <= '0;
            o_rd_addr <= '0;
        end else begin
            busy_q <= (state_nxt != S_IDLE);
            if (accept) begin
                op_q   <= i_funct3[1:0];
                rd_q   <= i_rd_addr;
                src1_q <= i_src1;
                src2_q <= i_src2;
                quo_q  <= dvd_mag_in;
                rem_q  <= '0;
                dvs_q  <= dvs_mag_in;
                cnt    <= is_div_in ? CW'(XLEN-1) : CW'(MUL_LAT-1);
                if (special_in) begin
                    o_result  <= special_res;
                    o_rd_addr <= i_rd_addr;
                end
            end else if (!i_flush && (state == S_MUL)) begin
                if (cnt == '0) begin
                    o_result  <= mul_res;
                    o_rd_addr <= rd_q;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end else if (!i_flush && (state == S_DIV)) begin
                rem_q <= rem_nxt;
                quo_q <= quo_nxt;
                if (cnt == '0) begin
                    o_result  <= div_res;
                    o_rd_addr <= rd_q;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

    // ---------------- outputs ----------------
    assign o_ex_stall = accept || (state == S_MUL) || (state == S_DIV);
    assign o_valid    = (state == S_DONE);
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_exu_muldiv.sv
module tb_exu_muldiv;

    localparam int XLEN    = 32;
    localparam int MUL_LAT = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_valid;
    logic [2:0]      i_funct3;
    logic [XLEN-1:0] i_src1;
    logic [XLEN-1:0] i_src2;
    logic [4:0]      i_rd_addr;
    logic            i_flush;
    logic            o_ex_stall;
    logic            o_valid;
    logic [XLEN-1:0] o_result;
    logic [4:0]      o_rd_addr;
    logic            o_busy;

    int tests  = 0;
    int failed = 0;

    exu_muldiv #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .i_funct3   (i_funct3),
        .i_src1     (i_src1),
        .i_src2     (i_src2),
        .i_rd_addr  (i_rd_addr),
        .i_flush    (i_flush),
        .o_ex_stall (o_ex_stall),
        .o_valid    (o_valid),
        .o_result   (o_result),
        .o_rd_addr  (o_rd_addr),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    // Reference: RV32M semantics with plain 64-bit / signed 32-bit arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0] ua, ub, p;
        int sa32, sb32;
        logic [31:0] r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        sa32 = a;
        sb32 = b;
        r = '0;
        case (f3)
            3'd0: begin p = ua * ub; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else r = sa32 / sb32;
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 0;
                else r = sa32 % sb32;
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3 < 3'd4) return MUL_LAT + 1;
        if (b == 0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 1;
    endfunction

    // Presents one op (held until the result cycle) and checks latency, stall, result and rd.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        logic [31:0] exp_res;
        int exp_lat;
        int cyc;
        bit seen;
        exp_res = ref_model(f3, a, b);
        exp_lat = ref_lat(f3, a, b);
        i_valid = 1'b1; i_funct3 = f3; i_src1 = a; i_src2 = b; i_rd_addr = rd;
        cyc = 0; seen = 0;
        while (!seen && cyc <= XLEN + 8) begin
            @(negedge clk);
            if (o_valid === 1'b1) begin
                seen = 1;
                tests++;
                if (cyc !== exp_lat) begin
                    failed++;
                    $display("FAIL latency f3=%0d a=%h b=%h: got %0d expected %0d", f3, a, b, cyc, exp_lat);
                end
                tests++;
                if (o_result !== exp_res) begin
                    failed++;
                    $display("FAIL result f3=%0d a=%h b=%h: got %h expected %h", f3, a, b, o_result, exp_res);
                end
                tests++;
                if (o_rd_addr !== rd) begin
                    failed++;
                    $display("FAIL rd_addr f3=%0d: got %0d expected %0d", f3, o_rd_addr, rd);
                end
                tests++;
                if (o_ex_stall !== 1'b0) begin
                    failed++;
                    $display("FAIL stall_at_valid f3=%0d: got %b expected 0", f3, o_ex_stall);
                end
            end else begin
                tests++;
                if (o_ex_stall !== 1'b1) begin
                    failed++;
                    $display("FAIL stall_pending f3=%0d cycle %0d: got %b expected 1", f3, cyc, o_ex_stall);
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (!seen) begin
            tests++; failed++;
            $display("FAIL timeout f3=%0d a=%h b=%h: no o_valid within %0d cycles, expected %0d", f3, a, b, cyc, exp_lat);
        end
        i_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_valid = 1'b0; i_funct3 = '0; i_src1 = '0; i_src2 = '0; i_rd_addr = '0; i_flush = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({o_valid, o_busy, o_ex_stall} !== 3'b000) begin
            failed++;
            $display("FAIL reset_ctrl: got valid/busy/stall=%b expected 000", {o_valid, o_busy, o_ex_stall});
        end
        tests++;
        if (o_result !== '0 || o_rd_addr !== '0) begin
            failed++;
            $display("FAIL reset_data: got result=%h rd=%0d expected 0/0", o_result, o_rd_addr);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6);
    endtask

    task automatic test_div();
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8);
        run_op(3'd5, 32'd100, 32'd7, 5'd9);
        run_op(3'd7, 32'd100, 32'd7, 5'd10);
    endtask

    task automatic test_special();
        run_op(3'd4, 32'd5, 32'd0, 5'd11);
        run_op(3'd6, 32'd5, 32'd0, 5'd12);
        run_op(3'd5, 32'd5, 32'd0, 5'd13);
        run_op(3'd7, 32'd5, 32'd0, 5'd14);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16);
        // Unsigned op with the same operands is an ordinary divide
        run_op(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17);
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = $urandom_range(0, 3);
                1: b = 32'hFFFF_FFFF;
                2: a = 32'h8000_0000;
                default: ;
            endcase
            run_op(3'($urandom_range(0, 7)), a, b, 5'($urandom_range(0, 31)));
        end
    endtask

    task automatic test_flush();
        // Flush at DIV cycle 10
        i_valid = 1'b1; i_funct3 = 3'd4; i_src1 = 32'd1000; i_src2 = 32'd3; i_rd_addr = 5'd20;
        repeat (10) begin @(posedge clk); #1; end
        i_flush = 1'b1;
        @(posedge clk); #1;
        i_flush = 1'b0; i_valid = 1'b0;
        @(negedge clk);
        tests++;
        if ({o_valid, o_ex_stall, o_busy} !== 3'b000) begin
            failed++;
            $display("FAIL flush_div: got valid/stall/busy=%b expected 000", {o_valid, o_ex_stall, o_busy});
        end
        @(posedge clk); #1;
        run_op(3'd0, 32'd12345, 32'd678, 5'd21);

        // Flush beats accept
        i_valid = 1'b1; i_funct3 = 3'd0; i_src1 = 32'd2; i_src2 = 32'd3; i_rd_addr = 5'd22; i_flush = 1'b1;
        @(negedge clk);
        tests++;
        if (o_ex_stall !== 1'b0) begin
            failed++;
            $display("FAIL flush_accept_stall: got %b expected 0", o_ex_stall);
        end
        @(posedge clk); #1;
        i_valid = 1'b0; i_flush = 1'b0;
        @(negedge clk);
        tests++;
        if (o_busy !== 1'b0) begin
            failed++;
            $display("FAIL flush_accept_busy: got %b expected 0", o_busy);
        end
        @(posedge clk); #1;

        // Flush in DONE keeps that cycle's pulse
        i_valid = 1'b1; i_funct3 = 3'd4; i_src1 = 32'd9; i_src2 = 32'd0; i_rd_addr = 5'd23;
        @(posedge clk); #1;
        i_flush = 1'b1;
        @(negedge clk);
        tests++;
        if (o_valid !== 1'b1 || o_result !== 32'hFFFF_FFFF) begin
            failed++;
            $display("FAIL flush_done: got valid=%b result=%h expected 1/ffffffff", o_valid, o_result);
        end
        @(posedge clk); #1;
        i_flush = 1'b0; i_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
            failed++;
            $display("FAIL flush_done_after: got valid=%b busy=%b expected 0/0", o_valid, o_busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int pulses;
        run_op(3'd5, 32'hDEAD_BEEF, 32'd1234, 5'd24);
        run_op(3'd1, 32'hFFFF_FFF0, 32'd77, 5'd25);

        // Reset mid-DIV: no pulse, everything back to zero
        i_valid = 1'b1; i_funct3 = 3'd6; i_src1 = 32'd999; i_src2 = 32'd10; i_rd_addr = 5'd26;
        repeat (15) begin @(posedge clk); #1; end
        rst = 1'b1; i_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({o_valid, o_ex_stall, o_busy} !== 3'b000 || o_result !== '0 || o_rd_addr !== '0) begin
            failed++;
            $display("FAIL rst_mid_div: got valid/stall/busy=%b result=%h rd=%0d expected all 0",
                     {o_valid, o_ex_stall, o_busy}, o_result, o_rd_addr);
        end
        pulses = 0;
        repeat (XLEN + 5) begin
            @(negedge clk);
            if (o_valid === 1'b1) pulses++;
        end
        tests++;
        if (pulses !== 0) begin
            failed++;
            $display("FAIL rst_no_pulse: got %0d pulses expected 0", pulses);
        end
        @(posedge clk); #1;
        run_op(3'd7, 32'd50, 32'd9, 5'd27);
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_random();
        test_flush();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
